// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals for mem_port_arbiter.
// The arbiter connects through the slave modport; the surrounding core and
// memory (or a bench) drive the master side.
interface mem_port_arbiter_if #(
    parameter int N_CH   = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [N_CH-1:0]          ch_request;
    logic [N_CH-1:0]          ch_we_re;
    logic [N_CH*ADDR_W-1:0]   ch_addr;
    logic [N_CH*DATA_W-1:0]   ch_wdata;
    logic [N_CH*DATA_W/8-1:0] ch_mask;
    logic [N_CH-1:0]          ch_grant;
    logic [N_CH-1:0]          ch_valid;
    logic                     ch_err;
    logic [DATA_W-1:0]        ch_rdata;
    logic                     mem_request;
    logic                     mem_we_re;
    logic [ADDR_W-1:0]        mem_addr;
    logic [DATA_W-1:0]        mem_wdata;
    logic [DATA_W/8-1:0]      mem_mask;
    logic                     mem_valid;
    logic [DATA_W-1:0]        mem_rdata;

    modport slave (
        input  ch_request, ch_we_re, ch_addr, ch_wdata, ch_mask,
        input  mem_valid, mem_rdata,
        output ch_grant, ch_valid, ch_err, ch_rdata,
        output mem_request, mem_we_re, mem_addr, mem_wdata, mem_mask
    );

    modport master (
        output ch_request, ch_we_re, ch_addr, ch_wdata, ch_mask,
        output mem_valid, mem_rdata,
        input  ch_grant, ch_valid, ch_err, ch_rdata,
        input  mem_request, mem_we_re, mem_addr, mem_wdata, mem_mask
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port among N_CH requesters. One transaction is in flight
// at a time: IDLE picks a winner and latches its payload onto mem_*, BUSY waits
// for mem_valid (or a timeout), RESP pulses ch_valid for one cycle.
module mem_port_arbiter #(
    parameter int N_CH     = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int ARB_MODE = 0,
    parameter int TIMEOUT  = 16
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    localparam int MASK_W = DATA_W / 8;
    localparam int IDX_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    // A zero-width counter is not legal, so a disabled timeout keeps one bit
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT);
    localparam logic [IDX_W-1:0] PTR_INIT = IDX_W'(N_CH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_r, state_nx;
    logic [IDX_W-1:0]    win_r, win_nx, rr_ptr_r, rr_nx, win_s;
    logic [CNT_W-1:0]    cnt_r, cnt_nx, cnt_inc_s;
    logic [N_CH-1:0]     grant_r, grant_nx, valid_r, valid_nx;
    logic                err_r, err_nx, mreq_r, mreq_nx, mwe_r, mwe_nx;
    logic [DATA_W-1:0]   rdata_r, rdata_nx, mwdata_r, mwdata_nx, sel_wdata_s;
    logic [ADDR_W-1:0]   maddr_r, maddr_nx, sel_addr_s;
    logic [MASK_W-1:0]   mmask_r, mmask_nx, sel_mask_s;
    logic                sel_we_s;

    function automatic logic [N_CH-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_CH-1:0] r;
        r = '0;
        for (int k = 0; k < N_CH; k++) begin
            r[k] = (idx == IDX_W'(k));
        end
        return r;
    endfunction

    // Arbitration: fixed gives the highest requesting index, round-robin the first requester after the pointer
    always_comb begin
        logic             found;
        logic [IDX_W-1:0] cand;
        found = 1'b0;
        cand  = '0;
        win_s = '0;
        if (ARB_MODE == 1) begin
            for (int k = 1; k <= N_CH; k++) begin
                cand  = IDX_W'((int'(rr_ptr_r) + k) % N_CH);
                win_s = (!found && bus.ch_request[cand]) ? cand : win_s;
                found = found | bus.ch_request[cand];
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                win_s = bus.ch_request[i] ? IDX_W'(i) : win_s;
            end
        end
    end

    // Payload mux for the channel that would win this cycle
    always_comb begin
        sel_we_s    = 1'b0;
        sel_addr_s  = '0;
        sel_wdata_s = '0;
        sel_mask_s  = '0;
        for (int i = 0; i < N_CH; i++) begin
            sel_we_s    = (win_s == IDX_W'(i)) ? bus.ch_we_re[i] : sel_we_s;
            sel_addr_s  = (win_s == IDX_W'(i)) ? bus.ch_addr[i*ADDR_W +: ADDR_W] : sel_addr_s;
            sel_wdata_s = (win_s == IDX_W'(i)) ? bus.ch_wdata[i*DATA_W +: DATA_W] : sel_wdata_s;
            sel_mask_s  = (win_s == IDX_W'(i)) ? bus.ch_mask[i*MASK_W +: MASK_W] : sel_mask_s;
        end
    end

    assign cnt_inc_s = cnt_r + 1'b1;

    // Next-state and next-output logic; all outputs come from registers
    always_comb begin
        state_nx  = state_r;
        win_nx    = win_r;
        rr_nx     = rr_ptr_r;
        cnt_nx    = cnt_r;
        grant_nx  = grant_r;
        valid_nx  = '0;
        err_nx    = 1'b0;
        rdata_nx  = rdata_r;
        mreq_nx   = mreq_r;
        mwe_nx    = mwe_r;
        maddr_nx  = maddr_r;
        mwdata_nx = mwdata_r;
        mmask_nx  = mmask_r;
        case (state_r)
            IDLE: begin
                if (|bus.ch_request) begin
                    win_nx    = win_s;
                    rr_nx     = win_s;
                    grant_nx  = onehot(win_s);
                    mreq_nx   = 1'b1;
                    mwe_nx    = sel_we_s;
                    maddr_nx  = sel_addr_s;
                    mwdata_nx = sel_wdata_s;
                    mmask_nx  = sel_mask_s;
                    cnt_nx    = '0;
                    state_nx  = BUSY;
                end else begin
                    grant_nx = '0;
                end
            end
            BUSY: begin
                // Completion beats a timeout falling on the same edge
                if (bus.mem_valid) begin
                    rdata_nx = mwe_r ? '0 : bus.mem_rdata;
                    valid_nx = onehot(win_r);
                    mreq_nx  = 1'b0;
                    state_nx = RESP;
                end else if ((TIMEOUT != 0) && (cnt_inc_s == TO_LIMIT)) begin
                    rdata_nx = '0;
                    valid_nx = onehot(win_r);
                    err_nx   = 1'b1;
                    mreq_nx  = 1'b0;
                    state_nx = RESP;
                end else begin
                    cnt_nx = cnt_inc_s;
                end
            end
            RESP: begin
                grant_nx = '0;
                cnt_nx   = '0;
                state_nx = IDLE;
            end
            default: begin
                grant_nx = '0;
                mreq_nx  = 1'b0;
                cnt_nx   = '0;
                state_nx = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r  <= IDLE;
            win_r    <= '0;
            rr_ptr_r <= PTR_INIT;
            cnt_r    <= '0;
            grant_r  <= '0;
            valid_r  <= '0;
            err_r    <= 1'b0;
            rdata_r  <= '0;
            mreq_r   <= 1'b0;
            mwe_r    <= 1'b0;
            maddr_r  <= '0;
            mwdata_r <= '0;
            mmask_r  <= '0;
        end else begin
            state_r  <= state_nx;
            win_r    <= win_nx;
            rr_ptr_r <= rr_nx;
            cnt_r    <= cnt_nx;
            grant_r  <= grant_nx;
            valid_r  <= valid_nx;
            err_r    <= err_nx;
            rdata_r  <= rdata_nx;
            mreq_r   <= mreq_nx;
            mwe_r    <= mwe_nx;
            maddr_r  <= maddr_nx;
            mwdata_r <= mwdata_nx;
            mmask_r  <= mmask_nx;
        end
    end

    assign bus.ch_grant    = grant_r;
    assign bus.ch_valid    = valid_r;
    assign bus.ch_err      = err_r;
    assign bus.ch_rdata    = rdata_r;
    assign bus.mem_request = mreq_r;
    assign bus.mem_we_re   = mwe_r;
    assign bus.mem_addr    = maddr_r;
    assign bus.mem_wdata   = mwdata_r;
    assign bus.mem_mask    = mmask_r;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance 0 is fixed priority, instance 1 is
// round-robin, both with TIMEOUT = 4. A transaction-level model predicts the
// outputs of both every cycle; directed scenarios add literal expectations.
module tb_mem_port_arbiter;
    localparam int N_CH = 2, ADDR_W = 32, DATA_W = 32, MASK_W = 4, TO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Stimulus per instance
    logic                     s_rst   [2];
    logic [N_CH-1:0]          s_req   [2];
    logic [N_CH-1:0]          s_we    [2];
    logic [N_CH*ADDR_W-1:0]   s_addr  [2];
    logic [N_CH*DATA_W-1:0]   s_wdata [2];
    logic [N_CH*MASK_W-1:0]   s_mask  [2];
    logic                     s_mv    [2];
    logic [DATA_W-1:0]        s_mrd   [2];
    // Observed outputs
    logic [N_CH-1:0]   o_grant [2], o_valid [2];
    logic              o_err [2], o_mreq [2], o_mwe [2];
    logic [DATA_W-1:0] o_rdata [2], o_mwdata [2];
    logic [ADDR_W-1:0] o_maddr [2];
    logic [MASK_W-1:0] o_mmask [2];
    // Model expectations
    logic [N_CH-1:0]   e_grant [2], e_valid [2];
    logic              e_err [2], e_mreq [2], e_mwe [2];
    logic [DATA_W-1:0] e_rdata [2], e_mwdata [2];
    logic [ADDR_W-1:0] e_maddr [2];
    logic [MASK_W-1:0] e_mmask [2];
    int m_ph [2];   // 0 idle, 1 waiting for memory, 2 response cycle
    int m_win [2], m_age [2], m_ptr [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_port_arbiter_if #(.N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
        assign bus.ch_request = s_req[g];
        assign bus.ch_we_re   = s_we[g];
        assign bus.ch_addr    = s_addr[g];
        assign bus.ch_wdata   = s_wdata[g];
        assign bus.ch_mask    = s_mask[g];
        assign bus.mem_valid  = s_mv[g];
        assign bus.mem_rdata  = s_mrd[g];
        assign o_grant[g]  = bus.ch_grant;
        assign o_valid[g]  = bus.ch_valid;
        assign o_err[g]    = bus.ch_err;
        assign o_rdata[g]  = bus.ch_rdata;
        assign o_mreq[g]   = bus.mem_request;
        assign o_mwe[g]    = bus.mem_we_re;
        assign o_maddr[g]  = bus.mem_addr;
        assign o_mwdata[g] = bus.mem_wdata;
        assign o_mmask[g]  = bus.mem_mask;
        mem_port_arbiter #(.N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                           .ARB_MODE(g), .TIMEOUT(TO)) u_dut (
            .clk(clk), .rst(s_rst[g]), .bus(bus)
        );
    end

    task automatic chk(input int d, input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL dut%0d %s: got %0h expected %0h at %0t", d, nm, act, exp, $time);
        end
    endtask

    function automatic bit req_bit(input int d, input int ch);
        return ((s_req[d] >> ch) & N_CH'(1)) != '0;
    endfunction

    // Winner from the arbitration rules: fixed = highest requester, RR = first after last winner
    function automatic int pick(input int d);
        int w;
        w = -1;
        if (d == 0) begin
            for (int i = 0; i < N_CH; i++) if (req_bit(d, i)) w = i;
        end else begin
            for (int k = 1; k <= N_CH; k++) begin
                int c;
                c = (m_ptr[d] + k) % N_CH;
                if (w < 0 && req_bit(d, c)) w = c;
            end
        end
        return w;
    endfunction

    task automatic model_step(input int d);
        int w;
        if (!s_rst[d]) begin
            m_ph[d] = 0; m_ptr[d] = N_CH - 1; m_age[d] = 0; m_win[d] = 0;
            e_grant[d] = '0; e_valid[d] = '0; e_err[d] = 1'b0; e_rdata[d] = '0;
            e_mreq[d] = 1'b0; e_mwe[d] = 1'b0; e_maddr[d] = '0; e_mwdata[d] = '0; e_mmask[d] = '0;
        end else begin
            e_valid[d] = '0;
            e_err[d]   = 1'b0;
            if (m_ph[d] == 0) begin
                if (s_req[d] != '0) begin
                    w = pick(d);
                    m_win[d] = w; m_ptr[d] = w; m_age[d] = 0; m_ph[d] = 1;
                    e_grant[d]  = N_CH'(1) << w;
                    e_mreq[d]   = 1'b1;
                    e_mwe[d]    = ((s_we[d] >> w) & N_CH'(1)) != '0;
                    e_maddr[d]  = ADDR_W'(s_addr[d] >> (w * ADDR_W));
                    e_mwdata[d] = DATA_W'(s_wdata[d] >> (w * DATA_W));
                    e_mmask[d]  = MASK_W'(s_mask[d] >> (w * MASK_W));
                end
            end else if (m_ph[d] == 1) begin
                if (s_mv[d]) begin
                    e_rdata[d] = e_mwe[d] ? '0 : s_mrd[d];
                    e_valid[d] = N_CH'(1) << m_win[d];
                    e_mreq[d]  = 1'b0;
                    m_ph[d]    = 2;
                end else begin
                    m_age[d]++;
                    if (m_age[d] == TO) begin
                        e_rdata[d] = '0;
                        e_valid[d] = N_CH'(1) << m_win[d];
                        e_err[d]   = 1'b1;
                        e_mreq[d]  = 1'b0;
                        m_ph[d]    = 2;
                    end
                end
            end else begin
                e_grant[d] = '0;
                m_age[d]   = 0;
                m_ph[d]    = 0;
            end
        end
    endtask

    task automatic compare_all();
        for (int d = 0; d < 2; d++) begin
            chk(d, "grant", 64'(o_grant[d]), 64'(e_grant[d]));
            chk(d, "valid", 64'(o_valid[d]), 64'(e_valid[d]));
            chk(d, "err", 64'(o_err[d]), 64'(e_err[d]));
            chk(d, "mem_request", 64'(o_mreq[d]), 64'(e_mreq[d]));
            if (e_mreq[d]) begin
                chk(d, "mem_we_re", 64'(o_mwe[d]), 64'(e_mwe[d]));
                chk(d, "mem_addr", 64'(o_maddr[d]), 64'(e_maddr[d]));
                chk(d, "mem_wdata", 64'(o_mwdata[d]), 64'(e_mwdata[d]));
                chk(d, "mem_mask", 64'(o_mmask[d]), 64'(e_mmask[d]));
            end
            if (e_valid[d] != '0) chk(d, "rdata", 64'(o_rdata[d]), 64'(e_rdata[d]));
        end
    endtask

    // One clock: model consumes the inputs present at the edge, outputs checked 1 time unit later
    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        compare_all();
    endtask

    task automatic set_ch(input int d, input int ch, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] mask);
        if (ch == 0) begin
            s_we[d][0] = we; s_addr[d][31:0] = addr; s_wdata[d][31:0] = wdata; s_mask[d][3:0] = mask;
        end else begin
            s_we[d][1] = we; s_addr[d][63:32] = addr; s_wdata[d][63:32] = wdata; s_mask[d][7:4] = mask;
        end
    endtask

    task automatic all_zero(input string nm);
        for (int d = 0; d < 2; d++) begin
            chk(d, {nm, " grant"}, 64'(o_grant[d]), 64'd0);
            chk(d, {nm, " valid"}, 64'(o_valid[d]), 64'd0);
            chk(d, {nm, " err"}, 64'(o_err[d]), 64'd0);
            chk(d, {nm, " mreq"}, 64'(o_mreq[d]), 64'd0);
            chk(d, {nm, " maddr"}, 64'(o_maddr[d]), 64'd0);
            chk(d, {nm, " rdata"}, 64'(o_rdata[d]), 64'd0);
        end
    endtask

    logic [N_CH-1:0] exp_g [4];
    int hi, seen;

    initial begin
        for (int d = 0; d < 2; d++) begin
            s_rst[d] = 1'b0; s_req[d] = '0; s_we[d] = '0; s_addr[d] = '0; s_wdata[d] = '0;
            s_mask[d] = '0; s_mv[d] = 1'b0; s_mrd[d] = '0;
            m_ph[d] = 0; m_win[d] = 0; m_age[d] = 0; m_ptr[d] = N_CH - 1;
        end
        tick(); tick();
        all_zero("reset");
        s_rst[0] = 1'b1; s_rst[1] = 1'b1;
        tick();

        // T1 single read on ch0, memory answers on the second waiting cycle
        s_req[0] = 2'b01; set_ch(0, 0, 1'b0, 32'h100, 32'h0, 4'hF);
        tick();
        chk(0, "t1 grant", 64'(o_grant[0]), 64'h1);
        chk(0, "t1 mreq0", 64'(o_mreq[0]), 64'h1);
        chk(0, "t1 maddr", 64'(o_maddr[0]), 64'h100);
        tick();
        chk(0, "t1 mreq1", 64'(o_mreq[0]), 64'h1);
        s_mv[0] = 1'b1; s_mrd[0] = 32'hDEADBEEF;
        tick();
        chk(0, "t1 valid", 64'(o_valid[0]), 64'h1);
        chk(0, "t1 rdata", 64'(o_rdata[0]), 64'hDEADBEEF);
        chk(0, "t1 err", 64'(o_err[0]), 64'h0);
        chk(0, "t1 mreq2", 64'(o_mreq[0]), 64'h0);
        s_mv[0] = 1'b0; s_req[0] = 2'b00;
        tick();

        // T2 fixed priority: ch1 beats ch0, ch0 served afterwards
        s_req[0] = 2'b11; set_ch(0, 0, 1'b0, 32'h10, 32'h0, 4'hF); set_ch(0, 1, 1'b0, 32'h20, 32'h0, 4'hF);
        tick();
        chk(0, "t2 grant1", 64'(o_grant[0]), 64'h2);
        chk(0, "t2 addr1", 64'(o_maddr[0]), 64'h20);
        s_mv[0] = 1'b1; s_mrd[0] = 32'h1111;
        tick();
        chk(0, "t2 valid1", 64'(o_valid[0]), 64'h2);
        s_mv[0] = 1'b0; s_req[0] = 2'b01;
        tick();
        chk(0, "t2 resp no grant", 64'(o_grant[0]), 64'h0);
        tick();
        chk(0, "t2 grant0", 64'(o_grant[0]), 64'h1);
        chk(0, "t2 addr0", 64'(o_maddr[0]), 64'h10);
        s_mv[0] = 1'b1; s_mrd[0] = 32'h2222;
        tick();
        chk(0, "t2 valid0", 64'(o_valid[0]), 64'h1);
        chk(0, "t2 rdata0", 64'(o_rdata[0]), 64'h2222);
        s_mv[0] = 1'b0; s_req[0] = 2'b00;
        tick();

        // T6 write on ch1 with distinct ch0 payload present
        s_req[0] = 2'b10; set_ch(0, 0, 1'b0, 32'h5555, 32'h77, 4'hC);
        set_ch(0, 1, 1'b1, 32'h2004, 32'hA5A50F0F, 4'b0011);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk(0, "t6 mreq", 64'(o_mreq[0]), 64'h1);
            chk(0, "t6 we", 64'(o_mwe[0]), 64'h1);
            chk(0, "t6 addr", 64'(o_maddr[0]), 64'h2004);
            chk(0, "t6 wdata", 64'(o_mwdata[0]), 64'hA5A50F0F);
            chk(0, "t6 mask", 64'(o_mmask[0]), 64'h3);
            set_ch(0, 1, 1'b0, 32'h9999, 32'h0, 4'hF);
        end
        s_mv[0] = 1'b1; s_mrd[0] = 32'hFFFFFFFF;
        tick();
        chk(0, "t6 valid", 64'(o_valid[0]), 64'h2);
        chk(0, "t6 rdata", 64'(o_rdata[0]), 64'h0);
        s_mv[0] = 1'b0; s_req[0] = 2'b00;
        tick();

        // T4 timeout with no memory answer
        s_req[0] = 2'b01; set_ch(0, 0, 1'b0, 32'h300, 32'h0, 4'hF);
        hi = 0; seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (o_mreq[0]) hi++;
            if (o_valid[0] != '0) begin
                seen = 1;
                break;
            end
        end
        chk(0, "t4 completion seen", 64'(seen), 64'd1);
        chk(0, "t4 mreq cycles", 64'(hi), 64'd4);
        chk(0, "t4 valid", 64'(o_valid[0]), 64'h1);
        chk(0, "t4 err", 64'(o_err[0]), 64'h1);
        chk(0, "t4 rdata", 64'(o_rdata[0]), 64'h0);
        s_req[0] = 2'b00;
        tick();

        // T3 round-robin order with both channels always requesting
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
        s_req[1] = 2'b11; set_ch(1, 0, 1'b0, 32'hA0, 32'h0, 4'hF); set_ch(1, 1, 1'b0, 32'hB0, 32'h0, 4'hF);
        for (int n = 0; n < 4; n++) begin
            tick();
            chk(1, "t3 grant order", 64'(o_grant[1]), 64'(exp_g[n]));
            s_mv[1] = 1'b1; s_mrd[1] = 32'(n);
            tick();
            chk(1, "t3 valid order", 64'(o_valid[1]), 64'(exp_g[n]));
            s_mv[1] = 1'b0;
            tick();
        end
        s_req[1] = 2'b00;
        tick();

        // T5 reset in the middle of a transaction, then a stray completion
        for (int d = 0; d < 2; d++) begin
            s_req[d] = 2'b01; set_ch(d, 0, 1'b0, 32'h40, 32'h0, 4'hF);
        end
        tick(); tick();
        s_rst[0] = 1'b0; s_rst[1] = 1'b0;
        tick();
        all_zero("t5");
        for (int d = 0; d < 2; d++) begin
            s_rst[d] = 1'b1; s_req[d] = 2'b00; s_mv[d] = 1'b1; s_mrd[d] = 32'h1234;
        end
        tick();
        chk(0, "t5 late valid", 64'(o_valid[0]), 64'h0);
        chk(1, "t5 late valid", 64'(o_valid[1]), 64'h0);
        s_mv[0] = 1'b0; s_mv[1] = 1'b0;
        tick();

        // Random traffic on both instances against the model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int d = 0; d < 2; d++) begin
                logic [N_CH-1:0] nr;
                s_rst[d]   = ($urandom_range(0, 199) != 0);
                s_mrd[d]   = $urandom;
                s_mv[d]    = e_mreq[d] ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
                s_addr[d]  = {$urandom, $urandom};
                s_wdata[d] = {$urandom, $urandom};
                s_mask[d]  = (N_CH * MASK_W)'($urandom);
                s_we[d]    = N_CH'($urandom);
                nr = '0;
                for (int ch = 0; ch < N_CH; ch++) begin
                    bit b;
                    if (req_bit(d, ch)) b = (((e_valid[d] >> ch) & N_CH'(1)) != '0) ? ($urandom_range(0, 1) == 1) : 1'b1;
                    else b = ($urandom_range(0, 3) == 0);
                    if (b) nr = nr | (N_CH'(1) << ch);
                end
                s_req[d] = nr;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
